// File: rtl/carry_look_ahead.sv
// carry_look_ahead: registered WIDTH-bit carry-lookahead adder.
// Each 4-bit block forms its carries as flat sum-of-products of g/p and the
// block carry-in. A second-level unit derives every block carry-in directly
// from block P/G and cin, so no carry ripples between or within blocks.
// The group P/G outputs let several instances feed a wider lookahead tree.
// WIDTH must be a positive multiple of 4.
module carry_look_ahead #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             group_p,
  output logic             group_g
);

  localparam int NB = WIDTH / 4;

  // Carries c1..c3 of one 4-bit block; none depends on another computed carry.
  function automatic logic [2:0] block_carries(input logic [3:0] g,
                                               input logic [3:0] p,
                                               input logic       c0);
    logic [2:0] c;
    c[0] = g[0] | (p[0] & c0);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // Block generate: carry out of a 4-bit block when its carry-in is zero.
  function automatic logic block_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Block propagate: carry-in passes through the whole block.
  function automatic logic block_prop(input logic [3:0] p);
    return p[3] & p[2] & p[1] & p[0];
  endfunction

  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] g_s;
  logic [NB-1:0]    bp_s;
  logic [NB-1:0]    bg_s;
  logic [NB:0]      bc_s;
  logic             word_p_s;
  logic             word_g_s;
  logic [WIDTH-1:0] sum_s;

  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             group_p_r;
  logic             group_g_r;

  // Bit-level propagate/generate and per-block P/G export.
  always_comb begin
    p_s  = a ^ b;
    g_s  = a & b;
    bp_s = '0;
    bg_s = '0;
    for (int blk = 0; blk < NB; blk++) begin
      bp_s[blk] = block_prop(p_s[4*blk +: 4]);
      bg_s[blk] = block_gen(g_s[4*blk +: 4], p_s[4*blk +: 4]);
    end
  end

  // Second-level lookahead: each block carry-in is a flat SOP of block P/G and cin.
  always_comb begin
    logic acc_s;
    logic term_s;
    bc_s    = '0;
    bc_s[0] = cin;
    for (int j = 1; j <= NB; j++) begin
      acc_s = 1'b0;
      for (int i = 0; i < j; i++) begin
        term_s = bg_s[i];
        for (int k = i + 1; k < j; k++) begin
          term_s = term_s & bp_s[k];
        end
        acc_s = acc_s | term_s;
      end
      term_s = cin;
      for (int k = 0; k < j; k++) begin
        term_s = term_s & bp_s[k];
      end
      bc_s[j] = acc_s | term_s;
    end
  end

  // Word-level group propagate/generate (generate is the carry out with cin=0).
  always_comb begin
    logic term_s;
    word_p_s = &bp_s;
    word_g_s = 1'b0;
    for (int i = 0; i < NB; i++) begin
      term_s = bg_s[i];
      for (int k = i + 1; k < NB; k++) begin
        term_s = term_s & bp_s[k];
      end
      word_g_s = word_g_s | term_s;
    end
  end

  // Sum bits: s[i] = p[i] ^ c[i] with in-block carries from the flat block equations.
  always_comb begin
    logic [2:0] c_s;
    sum_s = '0;
    for (int blk = 0; blk < NB; blk++) begin
      c_s = block_carries(g_s[4*blk +: 4], p_s[4*blk +: 4], bc_s[blk]);
      sum_s[4*blk +: 4] = p_s[4*blk +: 4] ^ {c_s, bc_s[blk]};
    end
  end

  // Output register: captures the combinational result every edge; reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r     <= '0;
      cout_r    <= 1'b0;
      group_p_r <= 1'b0;
      group_g_r <= 1'b0;
    end else begin
      sum_r     <= sum_s;
      cout_r    <= bc_s[NB];
      group_p_r <= word_p_s;
      group_g_r <= word_g_s;
    end
  end

  assign sum     = sum_r;
  assign cout    = cout_r;
  assign group_p = group_p_r;
  assign group_g = group_g_r;

endmodule

// File: tb/tb_carry_look_ahead.sv
// tb_carry_look_ahead: drives a 4-bit and a 16-bit instance side by side and
// compares their registered outputs with plain integer arithmetic.
module tb_carry_look_ahead;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  a4, b4, sum4;
  logic        cin4, cout4, gp4, gg4;
  logic [15:0] a16, b16, sum16;
  logic        cin16, cout16, gp16, gg16;

  int total = 0;
  int bad   = 0;

  carry_look_ahead #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4),
    .sum(sum4), .cout(cout4), .group_p(gp4), .group_g(gg4)
  );

  carry_look_ahead #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16),
    .sum(sum16), .cout(cout16), .group_p(gp16), .group_g(gg16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one vector to both instances, clock once, and check against arithmetic.
  task automatic step(input string tag,
                      input logic [3:0] x4, input logic [3:0] y4, input logic c4,
                      input logic [15:0] x16, input logic [15:0] y16, input logic c16);
    int e4, e16;
    a4 = x4; b4 = y4; cin4 = c4;
    a16 = x16; b16 = y16; cin16 = c16;
    @(posedge clk);
    #1;
    e4  = int'(x4) + int'(y4) + int'(c4);
    e16 = int'(x16) + int'(y16) + int'(c16);
    chk({tag, "_w4_total"}, {27'd0, cout4, sum4}, e4);
    chk({tag, "_w4_gp"}, {31'd0, gp4}, ((x4 ^ y4) == 4'hF) ? 32'd1 : 32'd0);
    chk({tag, "_w4_gg"}, {31'd0, gg4}, ((int'(x4) + int'(y4)) >= 16) ? 32'd1 : 32'd0);
    chk({tag, "_w4_cout_rel"}, {31'd0, cout4}, {31'd0, gg4 | (gp4 & c4)});
    chk({tag, "_w16_total"}, {15'd0, cout16, sum16}, e16);
    chk({tag, "_w16_gp"}, {31'd0, gp16}, ((x16 ^ y16) == 16'hFFFF) ? 32'd1 : 32'd0);
    chk({tag, "_w16_gg"}, {31'd0, gg16}, ((int'(x16) + int'(y16)) >= 65536) ? 32'd1 : 32'd0);
  endtask

  initial begin
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst_async_sum", {28'd0, sum4}, 32'd0);
    chk("rst_async_cout", {31'd0, cout4}, 32'd0);
    chk("rst_async_gp", {31'd0, gp4}, 32'd0);
    chk("rst_async_gg", {31'd0, gg4}, 32'd0);
    chk("rst_async_sum16", {16'd0, sum16}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_held_total", {27'd0, cout4, sum4}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_after_rst_w4", {27'd0, cout4, sum4}, 32'h1F);
    chk("first_after_rst_w16", {15'd0, cout16, sum16}, 32'h1FFFF);

    // Directed sequence.
    step("zero",  4'd0,  4'd0,  1'b0, 16'h0000, 16'h0000, 1'b0);
    step("one",   4'd1,  4'd0,  1'b0, 16'h0001, 16'h0000, 1'b0);
    step("s7",    4'd2,  4'd4,  1'b1, 16'h1234, 16'h4321, 1'b1);
    step("s9",    4'd5,  4'd3,  1'b1, 16'h00FF, 16'h0001, 1'b0);
    step("s8",    4'd5,  4'd3,  1'b0, 16'hFFFF, 16'h0001, 1'b0);
    step("s11",   4'd10, 4'd1,  1'b0, 16'hFFFF, 16'h0000, 1'b1);
    step("co17",  4'hB,  4'h6,  1'b0, 16'hFFFF, 16'h0000, 1'b0);
    step("co21",  4'd10, 4'd10, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    step("prop1", 4'hF,  4'h0,  1'b1, 16'h0F0F, 16'hF0F0, 1'b1);
    chk("prop1_sum", {28'd0, sum4}, 32'd0);
    chk("prop1_cout", {31'd0, cout4}, 32'd1);
    step("prop0", 4'hF,  4'h0,  1'b0, 16'h8000, 16'h8000, 1'b0);
    chk("prop0_sum", {28'd0, sum4}, 32'hF);

    // Reset asserted mid-operation discards the in-flight result.
    a4 = 4'h9; b4 = 4'h9; cin4 = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_total", {27'd0, cout4, sum4}, 32'd0);
    chk("mid_rst_total16", {15'd0, cout16, sum16}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive 4-bit sweep, back to back, 16-bit instance on random operands.
    for (int i = 0; i < 512; i++) begin
      step("sweep", i[3:0], i[7:4], i[8],
           16'($urandom), 16'($urandom), 1'($urandom));
    end

    // Extra random 16-bit traffic weighted toward long carry chains.
    for (int i = 0; i < 100; i++) begin
      logic [15:0] x;
      x = 16'($urandom);
      step("rand16", 4'($urandom), 4'($urandom), 1'($urandom),
           x, (i % 2 == 0) ? ~x : 16'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
